// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags for the Tomasulo core.
// Optional REG_FILE_COMMIT_BYPASS_EN forwards a same-cycle matching commit to the read ports.
module reg_file #(
    parameter int unsigned ROB_ID_WIDTH = 4,
    parameter int unsigned XLEN         = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    valid_from_issuer,
    input  logic [4:0]              rd_from_issuer,
    input  logic [ROB_ID_WIDTH-1:0] dest_from_issuer,
    input  logic [4:0]              rs1_from_issuer,
    input  logic [4:0]              rs2_from_issuer,
    output logic [ROB_ID_WIDTH-1:0] qj_to_issuer,
    output logic [XLEN-1:0]         vj_to_issuer,
    output logic [ROB_ID_WIDTH-1:0] qk_to_issuer,
    output logic [XLEN-1:0]         vk_to_issuer,
    input  logic [ROB_ID_WIDTH-1:0] dest_from_rob,
    input  logic [4:0]              rd_from_rob,
    input  logic [XLEN-1:0]         value_from_rob,
    input  logic                    reset_from_rob_bus
);

    localparam int unsigned NUM_REGS = 32;

    logic [XLEN-1:0]         value_q [NUM_REGS];
    logic [ROB_ID_WIDTH-1:0] tag_q   [NUM_REGS];

    logic commit_en;
    logic issue_en;
    logic commit_clears_tag;

    assign commit_en         = (dest_from_rob != ROB_ID_WIDTH'(0)) && (rd_from_rob != 5'd0);
    assign issue_en          = valid_from_issuer && (rd_from_issuer != 5'd0);
    assign commit_clears_tag = commit_en && (tag_q[rd_from_rob] == dest_from_rob);

    // State update: a flush drops all tags and any same-cycle issue; issue beats commit's tag clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else if (rdy) begin
            if (commit_en) begin
                value_q[rd_from_rob] <= value_from_rob;
            end
            if (reset_from_rob_bus) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    tag_q[i] <= '0;
                end
            end else begin
                if (commit_clears_tag) begin
                    tag_q[rd_from_rob] <= '0;
                end
                if (issue_en) begin
                    tag_q[rd_from_issuer] <= dest_from_issuer;
                end
            end
        end
    end

    // Read ports see pre-write state; x0 is hardwired to zero.
    always_comb begin
        qj_to_issuer = '0;
        vj_to_issuer = '0;
        qk_to_issuer = '0;
        vk_to_issuer = '0;
        if (rs1_from_issuer != 5'd0) begin
            qj_to_issuer = tag_q[rs1_from_issuer];
            vj_to_issuer = value_q[rs1_from_issuer];
`ifdef REG_FILE_COMMIT_BYPASS_EN
            if (commit_clears_tag && (rs1_from_issuer == rd_from_rob)) begin
                qj_to_issuer = '0;
                vj_to_issuer = value_from_rob;
            end
`endif
        end
        if (rs2_from_issuer != 5'd0) begin
            qk_to_issuer = tag_q[rs2_from_issuer];
            vk_to_issuer = value_q[rs2_from_issuer];
`ifdef REG_FILE_COMMIT_BYPASS_EN
            if (commit_clears_tag && (rs2_from_issuer == rd_from_rob)) begin
                qk_to_issuer = '0;
                vk_to_issuer = value_from_rob;
            end
`endif
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file (default build and REG_FILE_COMMIT_BYPASS_EN build).
module tb_reg_file;

    localparam int unsigned RW   = 4;
    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst, rdy, valid_from_issuer, reset_from_rob_bus;
    logic [4:0]      rd_from_issuer, rs1_from_issuer, rs2_from_issuer, rd_from_rob;
    logic [RW-1:0]   dest_from_issuer, dest_from_rob, qj_to_issuer, qk_to_issuer;
    logic [XLEN-1:0] vj_to_issuer, vk_to_issuer, value_from_rob;

    int checks   = 0;
    int failures = 0;

    reg_file #(.ROB_ID_WIDTH(RW), .XLEN(XLEN)) dut (
        .clk               (clk),
        .rst               (rst),
        .rdy               (rdy),
        .valid_from_issuer (valid_from_issuer),
        .rd_from_issuer    (rd_from_issuer),
        .dest_from_issuer  (dest_from_issuer),
        .rs1_from_issuer   (rs1_from_issuer),
        .rs2_from_issuer   (rs2_from_issuer),
        .qj_to_issuer      (qj_to_issuer),
        .vj_to_issuer      (vj_to_issuer),
        .qk_to_issuer      (qk_to_issuer),
        .vk_to_issuer      (vk_to_issuer),
        .dest_from_rob     (dest_from_rob),
        .rd_from_rob       (rd_from_rob),
        .value_from_rob    (value_from_rob),
        .reset_from_rob_bus(reset_from_rob_bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [RW-1:0] dest);
        valid_from_issuer = 1'b1;
        rd_from_issuer    = rd;
        dest_from_issuer  = dest;
    endtask

    task automatic commit(input logic [RW-1:0] dest, input logic [4:0] rd, input logic [XLEN-1:0] val);
        dest_from_rob  = dest;
        rd_from_rob    = rd;
        value_from_rob = val;
    endtask

    task automatic idle();
        valid_from_issuer  = 1'b0;
        rd_from_issuer     = '0;
        dest_from_issuer   = '0;
        reset_from_rob_bus = 1'b0;
        commit('0, '0, '0);
    endtask

    task automatic read(input logic [4:0] rs1, input logic [4:0] rs2);
        rs1_from_issuer = rs1;
        rs2_from_issuer = rs2;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        rs1_from_issuer = '0;
        rs2_from_issuer = '0;
        idle();
        step();
        step();
        rst = 1'b0;

        // Reset state on both ports, including x0
        read(5'd5, 5'd0);
        check("rst_qj_x5", 32'(qj_to_issuer), 32'd0);
        check("rst_vj_x5", vj_to_issuer, 32'd0);
        check("rst_qk_x0", 32'(qk_to_issuer), 32'd0);
        check("rst_vk_x0", vk_to_issuer, 32'd0);

        // rdy low blocks the issue
        rdy = 1'b0;
        issue(5'd5, 4'd3);
        step();
        check("rdy0_hold_qj", 32'(qj_to_issuer), 32'd0);
        rdy = 1'b1;

        // Rename then commit
        step();
        idle();
        check("issue_qj", 32'(qj_to_issuer), 32'd3);
        commit(4'd3, 5'd5, 32'h1234);
        #1;
`ifdef REG_FILE_COMMIT_BYPASS_EN
        check("bypass_qj", 32'(qj_to_issuer), 32'd0);
        check("bypass_vj", vj_to_issuer, 32'h1234);
`else
        check("precommit_qj", 32'(qj_to_issuer), 32'd3);
        check("precommit_vj", vj_to_issuer, 32'd0);
`endif
        step();
        idle();
        check("commit_qj", 32'(qj_to_issuer), 32'd0);
        check("commit_vj", vj_to_issuer, 32'h1234);

        // Older commit must not clear a younger producer's tag
        issue(5'd7, 4'd2);
        step();
        issue(5'd7, 4'd4);
        step();
        idle();
        read(5'd7, 5'd0);
        check("rename2_qj", 32'(qj_to_issuer), 32'd4);
        commit(4'd2, 5'd7, 32'hAA);
        #1;
        check("stale_commit_nobypass_qj", 32'(qj_to_issuer), 32'd4);
        step();
        idle();
        check("stale_commit_qj", 32'(qj_to_issuer), 32'd4);
        check("stale_commit_vj", vj_to_issuer, 32'hAA);

        // Same-cycle issue and commit to one rd: issue tag wins
        issue(5'd9, 4'd1);
        step();
        issue(5'd9, 4'd6);
        commit(4'd1, 5'd9, 32'h55);
        step();
        idle();
        read(5'd9, 5'd9);
        check("same_cycle_qj", 32'(qj_to_issuer), 32'd6);
        check("same_cycle_vj", vj_to_issuer, 32'h55);

        // Flush: tags clear, commit value lands, issue dropped
        issue(5'd3, 4'd2);
        step();
        issue(5'd4, 4'd7);
        step();
        issue(5'd10, 4'd8);
        step();
        idle();
        read(5'd3, 5'd10);
        check("preflush_qj_x3", 32'(qj_to_issuer), 32'd2);
        check("preflush_qk_x10", 32'(qk_to_issuer), 32'd8);
        reset_from_rob_bus = 1'b1;
        commit(4'd2, 5'd3, 32'h77);
        issue(5'd11, 4'd5);
        step();
        idle();
        read(5'd3, 5'd4);
        check("flush_qj_x3", 32'(qj_to_issuer), 32'd0);
        check("flush_vj_x3", vj_to_issuer, 32'h77);
        check("flush_qk_x4", 32'(qk_to_issuer), 32'd0);
        read(5'd10, 5'd11);
        check("flush_qj_x10", 32'(qj_to_issuer), 32'd0);
        check("flush_qk_x11", 32'(qk_to_issuer), 32'd0);
        read(5'd7, 5'd9);
        check("flush_qj_x7", 32'(qj_to_issuer), 32'd0);
        check("flush_vk_x9", vk_to_issuer, 32'h55);

        // Writes to x0 are ignored
        issue(5'd0, 4'd3);
        commit(4'd3, 5'd0, 32'hFF);
        step();
        idle();
        read(5'd0, 5'd0);
        check("x0_qj", 32'(qj_to_issuer), 32'd0);
        check("x0_vj", vj_to_issuer, 32'd0);
        check("x0_qk", 32'(qk_to_issuer), 32'd0);
        check("x0_vk", vk_to_issuer, 32'd0);

        // Commit forwarding on rs2 (only with the bypass build)
        issue(5'd12, 4'd9);
        step();
        idle();
        read(5'd0, 5'd12);
        commit(4'd10, 5'd12, 32'h1111);
        #1;
        check("nomatch_qk", 32'(qk_to_issuer), 32'd9);
        check("nomatch_vk", vk_to_issuer, 32'd0);
        commit(4'd9, 5'd12, 32'hBEEF);
        #1;
`ifdef REG_FILE_COMMIT_BYPASS_EN
        check("bypass_qk", 32'(qk_to_issuer), 32'd0);
        check("bypass_vk", vk_to_issuer, 32'hBEEF);
`else
        check("precommit_qk", 32'(qk_to_issuer), 32'd9);
        check("precommit_vk", vk_to_issuer, 32'd0);
`endif
        step();
        idle();
        check("post_commit_qk", 32'(qk_to_issuer), 32'd0);
        check("post_commit_vk", vk_to_issuer, 32'hBEEF);

        // rst wins over rdy=0
        issue(5'd12, 4'd5);
        step();
        idle();
        check("pre_rst_qk", 32'(qk_to_issuer), 32'd5);
        rdy = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        rdy = 1'b1;
        #1;
        check("rst_over_rdy_qk", 32'(qk_to_issuer), 32'd0);
        check("rst_over_rdy_vk", vk_to_issuer, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
